alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Iterative RV32M multiply/divide unit that consumes the two ALU operands produced by the operand-select stage and returns a 32-bit result after a fixed number of cycles. It sits beside the single-cycle ALU in execute. The pipeline stalls while it reports busy. It implements all eight M-extension ops with RISC-V-defined divide-by-zero and overflow results.

## Interface
- `WIDTH`, default 32: operand and result width. Equals `REG_WIDTH`.
- `CNT_W`, default 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.
- `clk`, input, 1: single clock. All state changes on rising edge.
- `rst_n`, input, 1: reset. **Synchronous, active-low.**
- `in_valid`, input, 1: operands and op valid this cycle.
- `in_ready`, output, 1: unit idle and able to accept.
- `op`, input, 3: instruction funct3.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `alu_src1`, input, WIDTH: rs1 operand, i.e. multiplicand or dividend.
- `alu_src2`, input, WIDTH: rs2 operand, i.e. multiplier or divisor.
- `kill`, input, 1: pipeline flush. Aborts any operation in progress.
- `out_valid`, output, 1: single-cycle pulse when `result` is new.
- `result`, output, WIDTH: final result. Held until the next completion.

## Operation
- **States:** IDLE, CALC, DONE. `in_ready` = (state==IDLE) && `rst_n`.
- **Accept:** `in_valid && in_ready && !kill` at a rising edge.
  - Latch `op`, both operands, and the sign flags.
  - Upstream may change its inputs freely after the accept edge.
- **Signedness:**
  - src1 is signed for MULH, MULHSU, DIV, REM.
  - src2 is signed for MULH, DIV, REM.
  - MUL is sign-agnostic; its low word is computed unsigned.
  - A signed operand is replaced by its magnitude (two's-complement negate if MSB=1). The core iterates unsigned.
- **Multiply:** shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
  - At DONE, negate the 2W product if (s1neg XOR s2neg).
  - MUL returns the low WIDTH bits. MULH, MULHSU, MULHU return the high WIDTH bits.
- **Divide:** restoring, one quotient bit per cycle.
  - Quotient is negated if signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
- **Special cases** are detected at accept and go IDLE→DONE directly, with no CALC:
  - Divisor 0: DIV/DIVU → all-ones (0xFFFFFFFF). REM/REMU → src1.
  - Signed overflow, src1=0x80000000 and src2=0xFFFFFFFF, DIV/REM only: DIV → 0x80000000, REM → 0.
- **Transitions:**
  - IDLE→CALC on accept, or IDLE→DONE if a special case.
  - CALC→DONE when the counter reaches WIDTH-1.
  - DONE→IDLE unconditionally.
- **Kill:** in any state, next state is IDLE, no `out_valid`, and `result` is unchanged.
  - Kill with `in_valid` in IDLE: no accept.
  - Kill wins over the CALC→DONE transition.
- **Reset:** state IDLE, counter 0, `out_valid` 0, `result` 0. `in_ready` is 0 while `rst_n`=0.
  - Reset mid-operation discards the operation with no output.

## Timing
- Accept in cycle k:
  - Normal op: CALC for cycles k+1 through k+WIDTH (32 cycles). DONE in cycle k+WIDTH+1, with `out_valid`=1 and `result` valid from that cycle.
  - Special case: DONE, `out_valid` and `result` all in cycle k+1.
- `result` is registered. It updates on the edge entering DONE and holds through IDLE.
- `in_ready` is low from k+1 through DONE. It is high again in the cycle after DONE, so back-to-back throughput is one op per WIDTH+2 cycles.
- `out_valid` is high for exactly one cycle per accepted, non-killed op.
- No combinational path from `in_valid` or operands to `out_valid` or `result`. `in_ready` depends only on state and `rst_n`.

## Test plan
- **MUL / MULHU:** MUL 7×6 → `result`=42, `out_valid` at k+33. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MUL of the same operands → 0x00000001.
- **Signed high and MULHSU:** MULH −2×3 (0xFFFFFFFE, 3) → 0xFFFFFFFF. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF. MUL −2×3 → 0xFFFFFFFA.
- **Division signs:**
  - DIV −7/2 → 0xFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFF (−1).
  - DIVU 100/7 → 14. REMU 100/7 → 2.
- **Special cases:** DIV 5/0 → 0xFFFFFFFF at k+1. REMU 5/0 → 5. DIV 0x80000000/−1 → 0x80000000. REM of the same operands → 0. Each asserts `out_valid` one cycle after accept.
- **Kill and reset:**
  - Assert `kill` at k+10 of a DIV: no `out_valid`, `in_ready`=1 at k+11, `result` keeps its prior value.
  - Drop `rst_n` at k+5: `in_ready`=0 during reset, `out_valid` never pulses, and a new op after release completes correctly.
- **Handshake:**
  - Hold `in_valid` high for two ops back-to-back. The second accept occurs at k+34.
  - Change operands during CALC: the first result is unaffected.
  - Hold `in_valid` with `kill` in IDLE: no accept.

Source files
------------

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit beside the execute-stage ALU.
// Shift-add multiply and restoring divide, one bit per cycle.
module alu_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] alu_src1,
   input  logic [WIDTH-1:0] alu_src2,
   input  logic             kill,
   output logic             out_valid,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       op_r;
   logic             s1neg;
   logic             s2neg;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   logic             s1_sgn;
   logic             s2_sgn;
   logic             s1neg_in;
   logic             s2neg_in;
   logic [WIDTH-1:0] mag1;
   logic [WIDTH-1:0] mag2;
   logic             div0;
   logic             ovf;
   logic             special;
   logic [WIDTH-1:0] spec_res;

   assign in_ready = (state == IDLE) && rst_n;

   always_comb begin
      s1_sgn   = (op == 3'b001) || (op == 3'b010) ||
                 (op == 3'b100) || (op == 3'b110);
      s2_sgn   = (op == 3'b001) || (op == 3'b100) ||
                 (op == 3'b110);
      s1neg_in = s1_sgn && alu_src1[WIDTH-1];
      s2neg_in = s2_sgn && alu_src2[WIDTH-1];
      mag1     = s1neg_in ? -alu_src1 : alu_src1;
      mag2     = s2neg_in ? -alu_src2 : alu_src2;
      div0     = op[2] && (alu_src2 == '0);
      ovf      = op[2] && !op[0] && (alu_src1 == MIN_NEG) &&
                 (alu_src2 == '1);
      special  = div0 || ovf;
      spec_res = div0 ? (op[1] ? alu_src1 : '1)
                      : (op[1] ? '0 : MIN_NEG);
   end

   // hi:lo is the product accumulator, or remainder:quotient when dividing
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_diff;
   logic               div_ok;
   logic [WIDTH-1:0]   hi_n;
   logic [WIDTH-1:0]   lo_n;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   q_s;
   logic [WIDTH-1:0]   r_s;
   logic [WIDTH-1:0]   fin;

   always_comb begin
      mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
      div_sh   = {hi, lo[WIDTH-1]};
      div_diff = div_sh - {1'b0, a};
      div_ok   = !div_diff[WIDTH];
      if (op_r[2]) begin
         hi_n = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
         lo_n = {lo[WIDTH-2:0], div_ok};
      end else begin
         hi_n = mul_sum[WIDTH:1];
         lo_n = {mul_sum[0], lo[WIDTH-1:1]};
      end
      prod_s = (s1neg ^ s2neg) ? -{hi_n, lo_n} : {hi_n, lo_n};
      q_s    = (s1neg ^ s2neg) ? -lo_n : lo_n;
      r_s    = s1neg ? -hi_n : hi_n;
      fin    = '0;
      unique case (op_r)
         3'b000:                 fin = prod_s[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: fin = prod_s[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         fin = q_s;
         default:                fin = r_s;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
         result    <= '0;
      end else begin
         out_valid <= 1'b0;
         if (kill) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (in_valid) begin
                     op_r  <= op;
                     s1neg <= s1neg_in;
                     s2neg <= s2neg_in;
                     a     <= op[2] ? mag2 : mag1;
                     lo    <= op[2] ? mag1 : mag2;
                     hi    <= '0;
                     cnt   <= '0;
                     if (special) begin
                        result    <= spec_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                     end else begin
                        state <= CALC;
                     end
                  end
               end
               CALC: begin
                  hi  <= hi_n;
                  lo  <= lo_n;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST) begin
                     result    <= fin;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboarded random and directed bench for alu_muldiv.
// Reference results come from plain 64-bit / int arithmetic.
module tb_alu_muldiv;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        kill = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] result;

   int cyc = 0;
   int total = 0;
   int bad = 0;
   logic [31:0] last_res = '0;

   typedef struct {
      logic [31:0] res;
      int          at;
   } exp_t;

   exp_t sb[$];

   alu_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .op(op),
      .alu_src1(src1),
      .alu_src2(src2),
      .kill(kill),
      .out_valid(out_valid),
      .result(result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [2:0] o,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
      logic [63:0] p;
      int sx;
      int sy;
      sx = x;
      sy = y;
      case (o)
         3'd0: begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
         3'd1: begin
            p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
            return p[63:32];
         end
         3'd2: begin p = {{32{x[31]}}, x} * {32'd0, y}; return p[63:32]; end
         3'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
         3'd4: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
            return sx / sy;
         end
         3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: begin
            if (y == 0) return x;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
            return sx % sy;
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] o,
                                     input logic [31:0] x,
                                     input logic [31:0] y);
      if (!o[2]) return 1'b0;
      if (y == 0) return 1'b1;
      return !o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         4: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out_valid: got 1 want 0 at cyc %0d",
                     cyc);
         end else begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("latency", 32'(cyc), 32'(e.at));
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: got %b want 1", in_ready);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] want);
      exp_t e;
      wait_ready();
      in_valid = 1'b1;
      op = o;
      src1 = x;
      src2 = y;
      @(posedge clk);
      #1;
      e.res = want;
      e.at = cyc + (is_special(o, x, y) ? 0 : 32);
      sb.push_back(e);
      last_res = want;
      in_valid = 1'b0;
      src1 = $urandom;
      src2 = $urandom;
      op = 3'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
         sb.delete();
      end
   endtask

   typedef struct {
      logic [2:0]  o;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] r;
   } vec_t;

   vec_t dir[14] = '{
      '{3'd0, 32'd7,          32'd6,          32'd42},
      '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE},
      '{3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001},
      '{3'd1, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF},
      '{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF},
      '{3'd0, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFA},
      '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD},
      '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF},
      '{3'd5, 32'd100,        32'd7,          32'd14},
      '{3'd7, 32'd100,        32'd7,          32'd2},
      '{3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF},
      '{3'd7, 32'd5,          32'd0,          32'd5},
      '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000},
      '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0}
   };

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int c1;
      int c2;
      int n;
      logic [2:0]  ro;
      logic [31:0] rx;
      logic [31:0] ry;

      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", {31'd0, in_ready}, 32'd1);

      foreach (dir[i]) issue(dir[i].o, dir[i].x, dir[i].y, dir[i].r);
      drain();

      // back-to-back with operands changed during CALC
      wait_ready();
      in_valid = 1'b1;
      op = 3'd5;
      src1 = 32'd1000;
      src2 = 32'd10;
      @(posedge clk);
      #1;
      c1 = cyc;
      e.res = 32'd100;
      e.at = c1 + 32;
      sb.push_back(e);
      src1 = 32'd123456;
      src2 = 32'd3;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      c2 = cyc;
      e.res = 32'd41152;
      e.at = c2 + 32;
      sb.push_back(e);
      last_res = 32'd41152;
      in_valid = 1'b0;
      check("b2b_gap", 32'(c2 - c1), 32'd34);
      drain();

      // kill held with in_valid in IDLE
      wait_ready();
      kill = 1'b1;
      in_valid = 1'b1;
      op = 3'd4;
      src1 = 32'd50;
      src2 = 32'd5;
      @(posedge clk);
      #1;
      check("kill_idle_ready", {31'd0, in_ready}, 32'd1);
      kill = 1'b0;
      in_valid = 1'b0;

      // kill during CALC at k+10
      wait_ready();
      in_valid = 1'b1;
      op = 3'd4;
      src1 = 32'd1000;
      src2 = 32'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      check("kill_ready", {31'd0, in_ready}, 32'd1);
      check("kill_result", result, last_res);
      repeat (40) @(negedge clk);

      // reset mid-operation at k+5
      wait_ready();
      in_valid = 1'b1;
      op = 3'd0;
      src1 = 32'd9;
      src2 = 32'd9;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("midrst_ready2", {31'd0, in_ready}, 32'd0);
      check("midrst_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      last_res = 32'd0;
      repeat (40) @(negedge clk);
      issue(3'd0, 32'd12, 32'd11, 32'd132);
      drain();

      for (int i = 0; i < 250; i++) begin
         ro = 3'($urandom);
         rx = rand_opnd();
         ry = rand_opnd();
         issue(ro, rx, ry, ref_res(ro, rx, ry));
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
